dmem_arbiter: RTL

- Shares the single data-memory port between two requesters:
  - committed stores from the ROB head;
  - speculative loads from the memory execution unit.
- Keeps at most one dmem transaction in flight.
- Gives stores priority, with a bound on how long a waiting load can starve.
- On `flush`, drops in-flight load data but never drops a committed store.
- Sits between the mem unit / ROB commit path and the data cache port.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between committed stores (ROB head)
// and speculative loads (memory execution unit).
//   - At most one dmem transaction in flight; a new request can be accepted
//     in IDLE or in the same cycle the outstanding one completes.
//   - Stores win arbitration, but after STARVE_MAX consecutive store grants
//     with a load waiting, the load is granted.
//   - flush turns an outstanding load into a dropped load (its data is
//     discarded) and blocks new loads; committed stores are never dropped.
// Ports:
//   clk, rst (async, active-high), flush
//   st_req/st_addr/st_wmask/st_wdata -> st_ack, st_done
//   ld_req/ld_addr/ld_rmask/ld_tag   -> ld_ack, ld_resp_valid/rdata/tag
//   dmem_addr/rmask/wmask/wdata (registered) <- dmem_rdata, dmem_resp
//   busy: a transaction is outstanding
module dmem_arbiter #(
  parameter int ROB_IDX_W  = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 st_req,
  input  logic [31:0]          st_addr,
  input  logic [3:0]           st_wmask,
  input  logic [31:0]          st_wdata,
  output logic                 st_ack,
  output logic                 st_done,
  input  logic                 ld_req,
  input  logic [31:0]          ld_addr,
  input  logic [3:0]           ld_rmask,
  input  logic [ROB_IDX_W-1:0] ld_tag,
  output logic                 ld_ack,
  output logic                 ld_resp_valid,
  output logic [31:0]          ld_resp_rdata,
  output logic [ROB_IDX_W-1:0] ld_resp_tag,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp,
  output logic                 busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] L_STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_WAIT = 2'd1,
    LD_WAIT = 2'd2,
    LD_DROP = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SW-1:0]          r_streak;
  logic [ROB_IDX_W-1:0]   r_tag_q;
  logic [31:0]            r_addr;
  logic [3:0]             r_rmask;
  logic [3:0]             r_wmask;
  logic [31:0]            r_wdata;

  logic w_resp;
  logic w_accept;
  logic w_ld_elig;
  logic w_ld_starved;
  logic w_st_grant;
  logic w_ld_grant;

  // A dmem_resp while IDLE is a stale pulse and must not complete anything.
  assign w_resp       = dmem_resp && (r_state != IDLE);
  // Accepting on the completion cycle gives back-to-back transactions.
  // Gated by rst so no ack is reported while reset is asserted.
  assign w_accept     = !rst && ((r_state == IDLE) || dmem_resp);
  assign w_ld_elig    = ld_req && !flush;
  assign w_ld_starved = w_ld_elig && (r_streak == L_STREAK_MAX);
  assign w_st_grant   = w_accept && st_req && !w_ld_starved;
  assign w_ld_grant   = w_accept && w_ld_elig && !w_st_grant;

  assign st_ack        = w_st_grant;
  assign ld_ack        = w_ld_grant;
  assign st_done       = w_resp && (r_state == ST_WAIT);
  // A flush arriving together with the response still kills the load data.
  assign ld_resp_valid = w_resp && (r_state == LD_WAIT) && !flush;
  assign ld_resp_rdata = dmem_rdata;
  assign ld_resp_tag   = r_tag_q;

  assign dmem_addr  = r_addr;
  assign dmem_rmask = r_rmask;
  assign dmem_wmask = r_wmask;
  assign dmem_wdata = r_wdata;
  assign busy       = (r_state != IDLE);

  // Transaction FSM and registered dmem request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tag_q <= '0;
      r_addr  <= 32'h0000_0000;
      r_rmask <= 4'h0;
      r_wmask <= 4'h0;
      r_wdata <= 32'h0000_0000;
    end else if (w_st_grant) begin
      r_state <= ST_WAIT;
      r_addr  <= st_addr;
      r_rmask <= 4'h0;
      r_wmask <= st_wmask;
      r_wdata <= st_wdata;
    end else if (w_ld_grant) begin
      r_state <= LD_WAIT;
      r_addr  <= ld_addr;
      r_rmask <= ld_rmask;
      r_wmask <= 4'h0;
      r_wdata <= 32'h0000_0000;
      r_tag_q <= ld_tag;
    end else if (w_resp) begin
      // Completion without a follow-on grant; addr/wdata intentionally held.
      r_state <= IDLE;
      r_rmask <= 4'h0;
      r_wmask <= 4'h0;
    end else if ((r_state == LD_WAIT) && flush) begin
      r_state <= LD_DROP;
    end else begin
      r_state <= r_state;
    end
  end

  // Consecutive store grants while a load is waiting (starvation bound).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (!ld_req || w_ld_grant) begin
      r_streak <= '0;
    end else if (w_st_grant && !flush && (r_streak != L_STREAK_MAX)) begin
      r_streak <= r_streak + SW'(1);
    end else begin
      r_streak <= r_streak;
    end
  end

endmodule
